tpu_cmdq_multichannel: RTL

//  Next-generation TPU command queue: NUM_CH independent FIFO channels of 128-bit GEMM descriptors,

---
 rtl/tpu_cmdq_multichannel.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/tpu_cmdq_multichannel.sv
// Multi-channel TPU command queue: per-channel descriptor FIFOs fed from staged register
// writes, dispatched to the TPU core by a round-robin arbiter with chain override.
module tpu_cmdq_multichannel #(
   parameter  int NUM_CH = 4,
   parameter  int DEPTH  = 8,
   localparam int CNT_W  = $clog2(DEPTH + 1),
   localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
   localparam int PTR_W  = $clog2(DEPTH)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      enable,
   input  logic                      wr_en,
   input  logic [1:0]                wr_sel,
   input  logic [CH_W-1:0]           wr_ch,
   input  logic [31:0]               wr_data,
   input  logic [NUM_CH-1:0]         flush,
   output logic                      cmd_valid,
   input  logic                      cmd_ready,
   output logic [127:0]              cmd_desc,
   output logic [CH_W-1:0]           cmd_ch,
   input  logic                      exec_done,
   output logic                      busy,
   output logic [NUM_CH*CNT_W-1:0]   ch_count,
   output logic [NUM_CH-1:0]         ch_empty,
   output logic [NUM_CH-1:0]         ch_full,
   output logic [NUM_CH-1:0]         ovf_flag,
   output logic [NUM_CH-1:0]         irq_pend,
   input  logic [NUM_CH-1:0]         irq_clr,
   output logic                      irq
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_EXEC} state_t;

   state_t            state_q;
   logic [31:0]       stage_q [3];
   logic [127:0]      mem_q [NUM_CH][DEPTH];
   logic [PTR_W-1:0]  rd_ptr_q [NUM_CH];
   logic [PTR_W-1:0]  wr_ptr_q [NUM_CH];
   logic [CNT_W-1:0]  cnt_q [NUM_CH];
   logic [CH_W-1:0]   rr_ptr_q;
   logic              irq_en_q, chain_q, last_chain_q;

   logic [NUM_CH-1:0] push_vec, pop_vec, wr_ok, ovf_set, empty_vec, full_vec, avail, irq_set;
   logic              sel_found;
   logic [CH_W-1:0]   sel_ch, cand;

   always_comb begin
      push_vec  = '0;
      pop_vec   = '0;
      wr_ok     = '0;
      ovf_set   = '0;
      empty_vec = '0;
      full_vec  = '0;
      ch_count  = '0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
         empty_vec[c] = (cnt_q[c] == '0);
         full_vec[c]  = (cnt_q[c] == CNT_W'(DEPTH));
         push_vec[c]  = wr_en && (wr_sel == 2'd3) && (wr_ch == CH_W'(c));
         pop_vec[c]   = (state_q == S_ISSUE) && cmd_ready && !flush[cmd_ch] && (cmd_ch == CH_W'(c));
         // A full channel still accepts a push when it is flushed or popped on the same edge
         wr_ok[c]     = push_vec[c] && (flush[c] || !full_vec[c] || pop_vec[c]);
         ovf_set[c]   = push_vec[c] && !wr_ok[c];
         ch_count[c*CNT_W +: CNT_W] = cnt_q[c];
      end
   end

   // Channels being flushed this edge are not eligible, so a stale head is never offered
   assign avail = ~empty_vec & ~flush;

   always_comb begin
      sel_found = 1'b0;
      sel_ch    = '0;
      cand      = '0;
      if (last_chain_q && avail[cmd_ch]) begin
         sel_found = 1'b1;
         sel_ch    = cmd_ch;
      end else begin
         for (int unsigned i = 0; i < NUM_CH; i++) begin
            cand = CH_W'((32'(rr_ptr_q) + i) % 32'(NUM_CH));
            if (!sel_found && avail[cand]) begin
               sel_found = 1'b1;
               sel_ch    = cand;
            end
         end
      end
   end

   always_comb begin
      irq_set = '0;
      if (state_q == S_EXEC && exec_done && irq_en_q) irq_set[cmd_ch] = 1'b1;
   end

   assign ch_empty = empty_vec;
   assign ch_full  = full_vec;
   assign busy     = (state_q != S_IDLE);
   assign irq      = |irq_pend;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned s = 0; s < 3; s++) stage_q[s] <= '0;
      end else if (wr_en) begin
         case (wr_sel)
            2'd0:    stage_q[0] <= wr_data;
            2'd1:    stage_q[1] <= wr_data;
            2'd2:    stage_q[2] <= wr_data;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
         if (wr_ok[c])
            mem_q[c][flush[c] ? '0 : wr_ptr_q[c]] <= {wr_data, stage_q[2], stage_q[1], stage_q[0]};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned c = 0; c < NUM_CH; c++) begin
            rd_ptr_q[c] <= '0;
            wr_ptr_q[c] <= '0;
            cnt_q[c]    <= '0;
         end
         ovf_flag <= '0;
      end else begin
         for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (flush[c]) begin
               rd_ptr_q[c] <= '0;
               wr_ptr_q[c] <= PTR_W'(wr_ok[c]);
               cnt_q[c]    <= CNT_W'(wr_ok[c]);
            end else begin
               if (wr_ok[c])   wr_ptr_q[c] <= wr_ptr_q[c] + PTR_W'(1);
               if (pop_vec[c]) rd_ptr_q[c] <= rd_ptr_q[c] + PTR_W'(1);
               cnt_q[c] <= cnt_q[c] + CNT_W'(wr_ok[c]) - CNT_W'(pop_vec[c]);
            end
         end
         ovf_flag <= (ovf_flag & ~irq_clr) | ovf_set;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         cmd_valid    <= 1'b0;
         cmd_desc     <= '0;
         cmd_ch       <= '0;
         rr_ptr_q     <= '0;
         irq_en_q     <= 1'b0;
         chain_q      <= 1'b0;
         last_chain_q <= 1'b0;
         irq_pend     <= '0;
      end else begin
         irq_pend <= (irq_pend & ~irq_clr) | irq_set;
         case (state_q)
            S_IDLE: begin
               if (enable && sel_found) begin
                  cmd_ch    <= sel_ch;
                  cmd_desc  <= mem_q[sel_ch][rd_ptr_q[sel_ch]];
                  cmd_valid <= 1'b1;
                  state_q   <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (flush[cmd_ch]) begin
                  cmd_valid <= 1'b0;
                  state_q   <= S_IDLE;
               end else if (cmd_ready) begin
                  cmd_valid <= 1'b0;
                  irq_en_q  <= cmd_desc[122];
                  chain_q   <= cmd_desc[120];
                  rr_ptr_q  <= (cmd_ch == CH_W'(NUM_CH - 1)) ? '0 : cmd_ch + CH_W'(1);
                  state_q   <= S_EXEC;
               end
            end
            S_EXEC: begin
               if (exec_done) begin
                  last_chain_q <= chain_q;
                  state_q      <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule
